// File: rtl/threshold_cfg_if.sv
// rtl/threshold_cfg_if.sv - host write port bundle for the threshold configuration controller
//
// Purpose : valid/ready write channel from the host register block into
//           threshold_cfg_ctrl, plus the illegal-address error pulse.
// Signals : cfg_valid  host -> ctrl  write request
//           cfg_ready  ctrl -> host  write can be accepted (controller idle)
//           cfg_color  host -> ctrl  colour index 0..5
//           cfg_field  host -> ctrl  field index 0..6 (6 = enable bit)
//           cfg_data   host -> ctrl  threshold byte / enable in bit 0
//           cfg_err    ctrl -> host  1-cycle pulse, accepted write was dropped
// Modports: master = host side, slave = controller side.
interface threshold_cfg_if;
    logic       cfg_valid;
    logic       cfg_ready;
    logic [2:0] cfg_color;
    logic [2:0] cfg_field;
    logic [7:0] cfg_data;
    logic       cfg_err;

    modport master (
        output cfg_valid, cfg_color, cfg_field, cfg_data,
        input  cfg_ready, cfg_err
    );

    modport slave (
        input  cfg_valid, cfg_color, cfg_field, cfg_data,
        output cfg_ready, cfg_err
    );
endinterface

// File: rtl/threshold_cfg_ctrl.sv
// rtl/threshold_cfg_ctrl.sv - shadow/active threshold bank with frame-boundary commit
//
// Purpose : holds shadow and active banks of YCbCr thresholds and per-colour
//           enables for the six-colour classifier. Host writes land in the
//           shadow bank; a commit request copies shadow to active on the next
//           vsync edge (or after COMMIT_TIMEOUT cycles if nonzero).
// Params  : VS_POL         active vsync level; the commit point is the edge into it
//           COMMIT_TIMEOUT cycles to wait for vsync once pending; 0 = forever
// Ports   : pixelclk, reset_n (async, active-low), i_vsync
//           cfg            threshold_cfg_if.slave host write channel
//           commit_req     pulse, schedule a shadow->active copy
//           pending        commit scheduled, not yet applied
//           commit_done    pulse on the cycle the active bank updates
//           commit_timeout pulse with commit_done when forced by timeout
//           th_active      active thresholds, byte (color*6+field)*8 +: 8
//           en_active      active per-colour enables
// Option  : THRESH_READBACK_EN adds rd_color/rd_field/rd_data shadow readback
//           with one cycle of latency.
module threshold_cfg_ctrl #(
    parameter bit          VS_POL         = 1'b1,
    parameter logic [23:0] COMMIT_TIMEOUT = 24'd0
) (
    input  logic           pixelclk,
    input  logic           reset_n,
    input  logic           i_vsync,
    threshold_cfg_if.slave cfg,
    input  logic           commit_req,
    output logic           pending,
    output logic           commit_done,
    output logic           commit_timeout,
`ifdef THRESH_READBACK_EN
    input  logic [2:0]     rd_color,
    input  logic [2:0]     rd_field,
    output logic [7:0]     rd_data,
`endif
    output logic [287:0]   th_active,
    output logic [5:0]     en_active
);
    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_PENDING = 1'b1
    } state_t;

    // Per colour, LSB first: Y_TL, Y_TH, CB_TL, CB_TH, CR_TL, CR_TH.
    localparam logic [287:0] TH_DEFAULT = {
        8'd90,  8'd60,  8'd140, 8'd90,  8'd130, 8'd70,   // yellow
        8'd74,  8'd50,  8'd127, 8'd85,  8'd140, 8'd90,   // orange
        8'd99,  8'd60,  8'd78,  8'd23,  8'd160, 8'd90,   // purple
        8'd120, 8'd0,   8'd250, 8'd160, 8'd120, 8'd0,    // green
        8'd140, 8'd80,  8'd245, 8'd156, 8'd135, 8'd50,   // blue
        8'd240, 8'd160, 8'd155, 8'd100, 8'd150, 8'd40    // red
    };
    localparam logic [5:0] EN_DEFAULT = 6'h3F;

    state_t        state;
    state_t        state_next;
    logic [23:0]   wait_cnt;
    logic [23:0]   wait_cnt_next;
    logic          vs_d;
    logic          vs_edge;
    logic          commit_now;
    logic          commit_by_timeout;
    logic [287:0]  th_shadow;
    logic [5:0]    en_shadow;
    logic          wr_fire;
    logic          wr_legal;
    logic [8:0]    wr_base;

    assign vs_edge       = (i_vsync == VS_POL) && (vs_d != VS_POL);
    assign cfg.cfg_ready = (state == ST_IDLE);
    assign pending       = (state == ST_PENDING);

    // Writes are only accepted while idle, which is what freezes the shadow
    // bank between a commit request and the copy.
    assign wr_fire  = cfg.cfg_valid && cfg.cfg_ready;
    assign wr_legal = (cfg.cfg_color <= 3'd5) && (cfg.cfg_field <= 3'd6);
    assign wr_base  = (9'(cfg.cfg_color) * 9'd6 + 9'(cfg.cfg_field)) << 3;

    always_comb begin
        state_next        = state;
        wait_cnt_next     = wait_cnt;
        commit_now        = 1'b0;
        commit_by_timeout = 1'b0;
        case (state)
            ST_IDLE: begin
                if (commit_req) begin
                    state_next    = ST_PENDING;
                    wait_cnt_next = '0;
                end
            end
            ST_PENDING: begin
                if (wait_cnt != '1) begin
                    wait_cnt_next = wait_cnt + 24'd1;
                end
                // The vsync edge wins over a coincident timeout.
                if (vs_edge) begin
                    commit_now = 1'b1;
                    state_next = ST_IDLE;
                end else if ((COMMIT_TIMEOUT != 24'd0) &&
                             (wait_cnt == COMMIT_TIMEOUT - 24'd1)) begin
                    commit_now        = 1'b1;
                    commit_by_timeout = 1'b1;
                    state_next        = ST_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge pixelclk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= ST_IDLE;
            wait_cnt <= '0;
            vs_d     <= !VS_POL;
        end else begin
            state    <= state_next;
            wait_cnt <= wait_cnt_next;
            vs_d     <= i_vsync;
        end
    end

    always_ff @(posedge pixelclk or negedge reset_n) begin
        if (!reset_n) begin
            th_shadow <= TH_DEFAULT;
            en_shadow <= EN_DEFAULT;
        end else if (wr_fire && wr_legal) begin
            if (cfg.cfg_field == 3'd6) begin
                en_shadow[cfg.cfg_color] <= cfg.cfg_data[0];
            end else begin
                th_shadow[wr_base +: 8] <= cfg.cfg_data;
            end
        end
    end

    always_ff @(posedge pixelclk or negedge reset_n) begin
        if (!reset_n) begin
            th_active      <= TH_DEFAULT;
            en_active      <= EN_DEFAULT;
            commit_done    <= 1'b0;
            commit_timeout <= 1'b0;
            cfg.cfg_err    <= 1'b0;
        end else begin
            commit_done    <= commit_now;
            commit_timeout <= commit_by_timeout;
            cfg.cfg_err    <= wr_fire && !wr_legal;
            if (commit_now) begin
                th_active <= th_shadow;
                en_active <= en_shadow;
            end
        end
    end

`ifdef THRESH_READBACK_EN
    logic [8:0] rd_base;

    assign rd_base = (9'(rd_color) * 9'd6 + 9'(rd_field)) << 3;

    always_ff @(posedge pixelclk or negedge reset_n) begin
        if (!reset_n) begin
            rd_data <= 8'h00;
        end else if ((rd_color > 3'd5) || (rd_field > 3'd6)) begin
            rd_data <= 8'h00;
        end else if (rd_field == 3'd6) begin
            rd_data <= {7'b0, en_shadow[rd_color]};
        end else begin
            rd_data <= th_shadow[rd_base +: 8];
        end
    end
`endif
endmodule

// File: tb/tb_threshold_cfg_ctrl.sv
// tb/tb_threshold_cfg_ctrl.sv - scoreboard bench for threshold_cfg_ctrl
module tb_threshold_cfg_ctrl;
    localparam int TMO = 100;

    logic         pixelclk = 1'b0;
    logic         reset_n = 1'b0;
    logic         i_vsync = 1'b0;
    logic         commit_req = 1'b0;
    logic         pending;
    logic         commit_done;
    logic         commit_timeout;
    logic [287:0] th_active;
    logic [5:0]   en_active;
`ifdef THRESH_READBACK_EN
    logic [2:0]   rd_color = 3'd0;
    logic [2:0]   rd_field = 3'd0;
    logic [7:0]   rd_data;
`endif

    threshold_cfg_if cfg();

    threshold_cfg_ctrl #(.VS_POL(1'b1), .COMMIT_TIMEOUT(24'd100)) dut (
        .pixelclk       (pixelclk),
        .reset_n        (reset_n),
        .i_vsync        (i_vsync),
        .cfg            (cfg),
        .commit_req     (commit_req),
        .pending        (pending),
        .commit_done    (commit_done),
        .commit_timeout (commit_timeout),
`ifdef THRESH_READBACK_EN
        .rd_color       (rd_color),
        .rd_field       (rd_field),
        .rd_data        (rd_data),
`endif
        .th_active      (th_active),
        .en_active      (en_active)
    );

    always #5 pixelclk = ~pixelclk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always @(posedge pixelclk) cyc <= cyc + 1;

    // Reference tables: [colour][Y_TL, Y_TH, CB_TL, CB_TH, CR_TL, CR_TH]
    int def_tab [6][6] = '{
        '{40, 150, 100, 155, 160, 240},
        '{50, 135, 156, 245,  80, 140},
        '{ 0, 120, 160, 250,   0, 120},
        '{90, 160,  23,  78,  60,  99},
        '{90, 140,  85, 127,  50,  74},
        '{70, 130,  90, 140,  60,  90}
    };
    logic [7:0] sh [6][6];
    bit         sh_en [6];

    typedef struct {
        int           cyc;
        bit           is_err;
        bit           tmo;
        logic [287:0] th;
        logic [5:0]   en;
    } exp_t;
    exp_t sb [$];

    logic [287:0] exp_th;
    logic [5:0]   exp_en;

    task automatic chk(input string name, input logic [287:0] act, input logic [287:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < 6; c++) begin
            sh_en[c] = 1'b1;
            for (int f = 0; f < 6; f++) sh[c][f] = 8'(def_tab[c][f]);
        end
    endtask

    function automatic logic [287:0] pack_th();
        logic [287:0] r;
        for (int c = 0; c < 6; c++)
            for (int f = 0; f < 6; f++) r[(c*6+f)*8 +: 8] = sh[c][f];
        return r;
    endfunction

    function automatic logic [5:0] pack_en();
        logic [5:0] r;
        for (int c = 0; c < 6; c++) r[c] = sh_en[c];
        return r;
    endfunction

    function automatic logic [287:0] default_th();
        logic [287:0] r;
        for (int c = 0; c < 6; c++)
            for (int f = 0; f < 6; f++) r[(c*6+f)*8 +: 8] = 8'(def_tab[c][f]);
        return r;
    endfunction

    // Monitor: pops the scoreboard when the DUT pulses an event, and keeps the
    // active bank compared against the last committed model snapshot.
    always @(negedge pixelclk) begin
        if (!reset_n) begin
            exp_th = default_th();
            exp_en = 6'h3F;
        end else begin
            while (sb.size() > 0 && sb[0].cyc < cyc) begin
                checks++;
                errors++;
                $display("FAIL event_missed expected_cyc=%0d err=%0d actual=none now=%0d",
                         sb[0].cyc, sb[0].is_err, cyc);
                void'(sb.pop_front());
            end
            if (cfg.cfg_err || commit_done) begin
                if (sb.size() == 0 || sb[0].cyc != cyc) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_event cyc=%0d cfg_err=%0b commit_done=%0b required=none",
                             cyc, cfg.cfg_err, commit_done);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("event_err", 288'(cfg.cfg_err), 288'(e.is_err));
                    chk("event_done", 288'(commit_done), 288'(!e.is_err));
                    chk("event_timeout", 288'(commit_timeout), 288'(e.tmo && !e.is_err));
                    if (!e.is_err) begin
                        exp_th = e.th;
                        exp_en = e.en;
                    end
                end
            end else begin
                chk("timeout_without_done", 288'(commit_timeout), 288'(0));
            end
        end
        chk("th_active", th_active, exp_th);
        chk("en_active", 288'(en_active), 288'(exp_en));
    end

    task automatic tick();
        @(posedge pixelclk);
        #1;
    endtask

    task automatic do_write(input int c, input int f, input logic [7:0] d);
        cfg.cfg_valid = 1'b1;
        cfg.cfg_color = 3'(c);
        cfg.cfg_field = 3'(f);
        cfg.cfg_data  = d;
        if (c > 5 || f > 6) sb.push_back('{cyc: cyc + 1, is_err: 1'b1, tmo: 1'b0, th: '0, en: '0});
        else if (f == 6) sh_en[c] = d[0];
        else sh[c][f] = d;
        tick();
        cfg.cfg_valid = 1'b0;
    endtask

    task automatic idle_vsync();
        i_vsync = 1'b1;
        tick();
        i_vsync = 1'b0;
        tick();
    endtask

    // d = 1..TMO: vsync edge d cycles after the request is taken; d = 0: no vsync, timeout.
    task automatic run_commit(input int d, input bit with_write);
        int entry;
        int ccyc;
        commit_req = 1'b1;
        if (with_write) begin
            int c = int'($urandom_range(0, 5));
            int f = int'($urandom_range(0, 6));
            logic [7:0] v = 8'($urandom);
            cfg.cfg_valid = 1'b1;
            cfg.cfg_color = 3'(c);
            cfg.cfg_field = 3'(f);
            cfg.cfg_data  = v;
            if (f == 6) sh_en[c] = v[0];
            else sh[c][f] = v;
        end
        entry = cyc + 1;
        ccyc  = entry + ((d == 0) ? TMO : d);
        sb.push_back('{cyc: ccyc, is_err: 1'b0, tmo: (d == 0), th: pack_th(), en: pack_en()});
        tick();
        commit_req    = 1'b0;
        cfg.cfg_valid = 1'b0;
        chk("pending_set", 288'(pending), 288'(1));
        chk("ready_low", 288'(cfg.cfg_ready), 288'(0));
        while (cyc < ccyc) begin
            if (d != 0 && cyc == entry + d - 1) i_vsync = 1'b1;
            cfg.cfg_valid = 1'($urandom_range(0, 1));
            cfg.cfg_color = 3'($urandom);
            cfg.cfg_field = 3'($urandom);
            cfg.cfg_data  = 8'($urandom);
            commit_req    = ($urandom_range(0, 7) == 0);
            tick();
        end
        cfg.cfg_valid = 1'b0;
        commit_req    = 1'b0;
        chk("pending_clear", 288'(pending), 288'(0));
        chk("ready_high", 288'(cfg.cfg_ready), 288'(1));
        i_vsync = 1'b0;
        tick();
    endtask

`ifdef THRESH_READBACK_EN
    task automatic rd_chk(input int c, input int f);
        logic [7:0] e;
        rd_color = 3'(c);
        rd_field = 3'(f);
        tick();
        if (c > 5 || f > 6) e = 8'h00;
        else if (f == 6) e = {7'b0, sh_en[c]};
        else e = sh[c][f];
        chk("rd_data", 288'(rd_data), 288'(e));
    endtask
`endif

    initial begin
        #1000000;
        $display("FAIL watchdog expired at cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        cfg.cfg_valid = 1'b0;
        cfg.cfg_color = 3'd0;
        cfg.cfg_field = 3'd0;
        cfg.cfg_data  = 8'd0;
        model_reset();
        exp_th = default_th();
        exp_en = 6'h3F;
        repeat (3) tick();
        reset_n = 1'b1;
        tick();

        chk("rst_red_y_tl", 288'(th_active[7:0]), 288'(40));
        chk("rst_yellow_cr_th", 288'(th_active[287:280]), 288'(90));
        chk("rst_en", 288'(en_active), 288'(6'h3F));
        chk("rst_ready", 288'(cfg.cfg_ready), 288'(1));
        chk("rst_pending", 288'(pending), 288'(0));
        chk("rst_err", 288'(cfg.cfg_err), 288'(0));
        chk("rst_done", 288'(commit_done), 288'(0));

        // Shadow write is invisible until committed, vsync alone does nothing.
        do_write(0, 4, 8'd170);
        repeat (3) idle_vsync();
        chk("red_cr_tl_uncommitted", 288'(th_active[39:32]), 288'(160));
        run_commit(3, 1'b0);
        chk("red_cr_tl_committed", 288'(th_active[39:32]), 288'(170));

        // Illegal addresses: colour 7 and field 7.
        do_write(7, 0, 8'd55);
        do_write(2, 7, 8'd66);
        tick();
`ifdef THRESH_READBACK_EN
        rd_chk(0, 0);
        rd_chk(0, 4);
        rd_chk(7, 0);
        rd_chk(1, 6);
`endif

        // Timeout, edge on the first pending cycle, edge coinciding with timeout,
        // and a write accepted in the same cycle as the request.
        run_commit(0, 1'b0);
        run_commit(1, 1'b0);
        run_commit(TMO, 1'b0);
        run_commit(7, 1'b1);

        for (int it = 0; it < 20; it++) begin
            int nw = int'($urandom_range(1, 4));
            for (int w = 0; w < nw; w++)
                do_write(int'($urandom_range(0, 7)), int'($urandom_range(0, 7)), 8'($urandom));
            if ($urandom_range(0, 1) == 1) idle_vsync();
`ifdef THRESH_READBACK_EN
            rd_chk(int'($urandom_range(0, 7)), int'($urandom_range(0, 7)));
`endif
            run_commit(($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(1, 60)),
                       1'($urandom_range(0, 1)));
        end

        // Reset while pending: both banks back to defaults and no commit follows.
        do_write(1, 6, 8'd0);
        commit_req = 1'b1;
        tick();
        commit_req = 1'b0;
        repeat (10) tick();
        chk("pending_before_reset", 288'(pending), 288'(1));
        reset_n = 1'b0;
        model_reset();
        #1;
        chk("reset_en", 288'(en_active), 288'(6'h3F));
        chk("reset_pending", 288'(pending), 288'(0));
        repeat (2) tick();
        reset_n = 1'b1;
        repeat (TMO + 20) tick();
        run_commit(4, 1'b0);

        repeat (5) tick();
        chk("scoreboard_empty", 288'(sb.size()), 288'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
